// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared FSM encoding and width helpers for clk_rst_ctrl.
package clk_rst_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Plain vector constants so the FSM register stays a simple logic vector.
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = WAIT_LOCK;
  localparam logic [STATE_W-1:0] ST_HOLD      = HOLD;
  localparam logic [STATE_W-1:0] ST_RUN       = RUN;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_rst_ctrl_if.sv
// clk_rst_ctrl_if: lock input, divisor programming and reset/enable outputs
// of clk_rst_ctrl. lock_loss_cnt exists only when CLK_RST_LOCK_LOSS_CNT_EN
// is defined.
interface clk_rst_ctrl_if
  import clk_rst_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  localparam int SEL_W = sel_width(NUM_CH);

  logic              pll_locked;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [DIV_W-1:0]  div_data;
  logic              lost_clr;
  logic              rst_out;
  logic              ready;
  logic [NUM_CH-1:0] ce_out;
  logic              lock_lost;
  logic              div_busy;
`ifdef CLK_RST_LOCK_LOSS_CNT_EN
  logic [7:0]        lock_loss_cnt;
`endif

  modport master (
    output pll_locked, div_wr, div_sel, div_data, lost_clr,
`ifdef CLK_RST_LOCK_LOSS_CNT_EN
    input  lock_loss_cnt,
`endif
    input  rst_out, ready, ce_out, lock_lost, div_busy
  );

  modport slave (
    input  pll_locked, div_wr, div_sel, div_data, lost_clr,
`ifdef CLK_RST_LOCK_LOSS_CNT_EN
    output lock_loss_cnt,
`endif
    output rst_out, ready, ce_out, lock_lost, div_busy
  );

endinterface

// File: rtl/ce_divider.sv
// ce_divider: one clock-enable channel. Down-counter with terminal-count
// pulse, divisor register and a single pending shadow for runtime updates.
module ce_divider #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_q_i,   // controller is in RUN this cycle
  input  logic             run_d_i,   // controller will be in RUN next cycle
  input  logic             wr_i,
  input  logic [DIV_W-1:0] data_i,
  output logic             ce_o,
  output logic             busy_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             ce_q, ce_d;

  logic             reload;
  logic             pend_eff;
  logic [DIV_W-1:0] shadow_eff;
  logic             apply;

  // Next-state: shadow capture, divisor apply, count/reload and enable pulse.
  always_comb begin
    reload     = run_q_i && (cnt_q == '0);
    pend_eff   = wr_i || pending_q;
    shadow_eff = wr_i ? data_i : shadow_q;
    shadow_d   = shadow_eff;
    div_d      = div_q;
    pending_d  = pend_eff;
    apply      = 1'b0;

    if (run_q_i) begin
      // A write landing on the reload cycle is taken by that reload.
      apply = reload && pend_eff;
      if (apply) begin
        div_d     = shadow_eff;
        pending_d = 1'b0;
      end
    end else begin
      // Idle: a registered shadow lands one edge after its write.
      apply = pending_q;
      if (apply) begin
        div_d     = shadow_q;
        pending_d = wr_i;
      end
    end

    if (!run_q_i || !run_d_i || reload) begin
      cnt_d = div_d;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end

    ce_d = run_d_i && (cnt_d == '0);
  end

  // Channel state registers; async reset drops any pending shadow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= DIV_W'(DIV_DEFAULT);
      div_q     <= DIV_W'(DIV_DEFAULT);
      shadow_q  <= DIV_W'(DIV_DEFAULT);
      pending_q <= 1'b0;
      ce_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ce_q      <= ce_d;
    end
  end

  assign ce_o   = ce_q;
  assign busy_o = pending_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// clk_rst_ctrl: PLL lock synchroniser, reset sequencer and NUM_CH
// programmable clock-enable generators. Defining CLK_RST_LOCK_LOSS_CNT_EN
// adds a saturating lock-loss counter on the interface.
//
// state     | meaning
// WAIT_LOCK | reset held, waiting for synchronised lock
// HOLD      | lock seen, counting LOCK_HOLD stable cycles
// RUN       | reset released, enables running
module clk_rst_ctrl
  import clk_rst_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 0,
  parameter int LOCK_HOLD   = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clock_in,
  input  logic         reset,
  clk_rst_ctrl_if.slave bus
);

  localparam int SEL_W  = sel_width(NUM_CH);
  localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  logic [STATE_W-1:0] state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               rst_out_q, ready_q, lost_q, lost_d;
  logic               run_q, run_d, lost_set;

  logic [NUM_CH-1:0]  ce_w, busy_w;

  // Lock flag synchroniser into clock_in.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Sequencer next-state and hold timer.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        hold_d = '0;
        if (locked_s) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        hold_d  = '0;
      end
    endcase
  end

  assign run_q    = (state_q == ST_RUN);
  assign run_d    = (state_d == ST_RUN);
  assign lost_set = run_q && !locked_s;

  // Sticky loss flag: a new loss beats a simultaneous clear.
  always_comb begin
    lost_d = lost_q;
    if (lost_set)          lost_d = 1'b1;
    else if (bus.lost_clr) lost_d = 1'b0;
  end

  // Sequencer registers; outputs follow the next state so they switch on
  // the transition edge itself.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= ST_WAIT_LOCK;
      hold_q    <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rst_out_q <= !run_d;
      ready_q   <= run_d;
      lost_q    <= lost_d;
    end
  end

`ifdef CLK_RST_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  // Saturating loss counter; an increment with a clear restarts at 1.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      loss_cnt_q <= 8'd0;
    end else if (lost_set) begin
      if (bus.lost_clr)              loss_cnt_q <= 8'd1;
      else if (loss_cnt_q != 8'hFF)  loss_cnt_q <= loss_cnt_q + 8'd1;
    end else if (bus.lost_clr) begin
      loss_cnt_q <= 8'd0;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ce_divider #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_div (
      .clk_i   (clock_in),
      .rst_i   (reset),
      .run_q_i (run_q),
      .run_d_i (run_d),
      .wr_i    (bus.div_wr && (bus.div_sel == SEL_W'(i))),
      .data_i  (bus.div_data),
      .ce_o    (ce_w[i]),
      .busy_o  (busy_w[i])
    );
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.ready     = ready_q;
  assign bus.lock_lost = lost_q;
  assign bus.ce_out    = ce_w;
  assign bus.div_busy  = |busy_w;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// tb_clk_rst_ctrl: directed bench for clk_rst_ctrl. Three channels are used
// so that select code 3 is a genuinely out-of-range channel.
module tb_clk_rst_ctrl;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 16;
  localparam int LOCK_HOLD   = 16;
  localparam int SYNC_STAGES = 2;
  localparam int REL  = SYNC_STAGES + LOCK_HOLD + 1;  // edges from lock to release
  localparam int LOSS = SYNC_STAGES + 1;              // edges from drop to reset

  logic clock_in = 1'b0;
  logic reset    = 1'b1;
  int   errors   = 0;
  int   checks   = 0;

  clk_rst_ctrl_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clk_rst_ctrl #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (0),
    .LOCK_HOLD   (LOCK_HOLD),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic test_reset();
    bus.pll_locked = 1'b0;
    bus.div_wr     = 1'b0;
    bus.div_sel    = '0;
    bus.div_data   = '0;
    bus.lost_clr   = 1'b0;
    reset          = 1'b1;
    repeat (3) step();
    checks++; if (bus.rst_out !== 1'b1) begin errors++; $display("FAIL reset_rst_out got=%b exp=1", bus.rst_out); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.ce_out !== 3'b000) begin errors++; $display("FAIL reset_ce_out got=%b exp=000", bus.ce_out); end
    checks++; if (bus.lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got=%b exp=0", bus.lock_lost); end
    checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL reset_div_busy got=%b exp=0", bus.div_busy); end
    reset = 1'b0;
    step();
  endtask

  // Idle write: shadow captured on one edge, applied on the next.
  task automatic test_idle_write();
    bus.div_wr = 1'b1; bus.div_sel = 2'd1; bus.div_data = 16'd3;
    step();
    bus.div_wr = 1'b0;
    checks++; if (bus.div_busy !== 1'b1) begin errors++; $display("FAIL idle_busy_set got=%b exp=1", bus.div_busy); end
    step();
    checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL idle_busy_clear got=%b exp=0", bus.div_busy); end
  endtask

  task automatic test_glitch();
    int bad = 0;
    bus.pll_locked = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.rst_out !== 1'b1 || bus.ready !== 1'b0) bad++;
    end
    bus.pll_locked = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.rst_out !== 1'b1 || bus.ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL glitch_hold_reset bad_cycles=%0d exp=0", bad); end
  endtask

  // Full release after lock; leaves the bench sampling RUN cycle 0.
  task automatic test_release();
    int early = 0;
    bus.pll_locked = 1'b1;
    for (int k = 1; k <= REL; k++) begin
      step();
      if (k < REL && bus.rst_out !== 1'b1) early++;
      if (k == REL - 1) begin
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL release_ready_early got=%b exp=0", bus.ready); end
      end
    end
    checks++; if (early != 0) begin errors++; $display("FAIL release_early_fall cycles=%0d exp=0", early); end
    checks++; if (bus.rst_out !== 1'b0) begin errors++; $display("FAIL release_rst_out got=%b exp=0", bus.rst_out); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.lock_lost !== 1'b0) begin errors++; $display("FAIL release_lock_lost got=%b exp=0", bus.lock_lost); end
  endtask

  // div0=0, div1=3, div2=0 over RUN cycles 0..11.
  task automatic test_ce();
    logic [2:0] exp;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      exp = {1'b1, (c % 4 == 3), 1'b1};
      checks++; if (bus.ce_out !== exp) begin errors++; $display("FAIL ce_pattern cycle=%0d got=%b exp=%b", c, bus.ce_out, exp); end
    end
  endtask

  // Runs from RUN cycle 11 through 29.
  task automatic test_run_write();
    logic [2:0] exp;
    logic       exp_busy;
    step();  // cycle 12, channel 1 count = 3
    bus.div_wr = 1'b1; bus.div_sel = 2'd1; bus.div_data = 16'd1;
    step();  // cycle 13
    bus.div_wr = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      exp_busy = (j < 3);
      exp      = {1'b1, (j == 2 || j == 4 || j == 6), 1'b1};
      checks++; if (bus.div_busy !== exp_busy) begin errors++; $display("FAIL run_write_busy cycle=%0d got=%b exp=%b", 13 + j, bus.div_busy, exp_busy); end
      checks++; if (bus.ce_out !== exp) begin errors++; $display("FAIL run_write_ce cycle=%0d got=%b exp=%b", 13 + j, bus.ce_out, exp); end
    end
    // cycle 20: out-of-range select must touch nothing
    bus.div_wr = 1'b1; bus.div_sel = 2'd3; bus.div_data = 16'd5;
    step();  // cycle 21
    bus.div_wr = 1'b0;
    for (int c = 21; c <= 25; c++) begin
      if (c > 21) step();
      exp = {1'b1, (c % 2 == 1), 1'b1};
      checks++; if (bus.ce_out !== exp || bus.div_busy !== 1'b0) begin errors++; $display("FAIL bad_sel cycle=%0d ce=%b busy=%b exp_ce=%b exp_busy=0", c, bus.ce_out, bus.div_busy, exp); end
    end
    // cycle 25 is a reload cycle; a write now is taken by that reload
    bus.div_wr = 1'b1; bus.div_sel = 2'd1; bus.div_data = 16'd2;
    step();  // cycle 26
    bus.div_wr = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      exp = {1'b1, (j == 2), 1'b1};
      checks++; if (bus.ce_out !== exp || bus.div_busy !== 1'b0) begin errors++; $display("FAIL reload_write cycle=%0d ce=%b busy=%b exp_ce=%b exp_busy=0", 26 + j, bus.ce_out, bus.div_busy, exp); end
    end
  endtask

  task automatic test_loss();
    int early = 0;
    bus.pll_locked = 1'b0;
    for (int k = 1; k <= LOSS; k++) begin
      step();
      if (k < LOSS && bus.rst_out !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL loss_early cycles=%0d exp=0", early); end
    checks++; if (bus.rst_out !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL loss_rst rst_out=%b ready=%b exp=1/0", bus.rst_out, bus.ready); end
    checks++; if (bus.ce_out !== 3'b000) begin errors++; $display("FAIL loss_ce got=%b exp=000", bus.ce_out); end
    checks++; if (bus.lock_lost !== 1'b1) begin errors++; $display("FAIL loss_flag got=%b exp=1", bus.lock_lost); end
`ifdef CLK_RST_LOCK_LOSS_CNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt_one got=%0d exp=1", bus.lock_loss_cnt); end
`endif
    bus.lost_clr = 1'b1;
    step();
    bus.lost_clr = 1'b0;
    checks++; if (bus.lock_lost !== 1'b0) begin errors++; $display("FAIL lost_clr got=%b exp=0", bus.lock_lost); end
`ifdef CLK_RST_LOCK_LOSS_CNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL loss_cnt_clr got=%0d exp=0", bus.lock_loss_cnt); end
`endif
    bus.pll_locked = 1'b1;
    repeat (REL) step();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL relock_ready got=%b exp=1", bus.ready); end
    bus.pll_locked = 1'b0;
    repeat (LOSS - 1) step();
    bus.lost_clr = 1'b1;  // coincides with the loss edge
    step();
    bus.lost_clr = 1'b0;
    checks++; if (bus.lock_lost !== 1'b1) begin errors++; $display("FAIL set_beats_clr got=%b exp=1", bus.lock_lost); end
`ifdef CLK_RST_LOCK_LOSS_CNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt_set_clr got=%0d exp=1", bus.lock_loss_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    bus.pll_locked = 1'b1;
    repeat (6) step();
    bus.div_wr = 1'b1; bus.div_sel = 2'd0; bus.div_data = 16'd9;
    step();
    bus.div_wr = 1'b0;
    checks++; if (bus.div_busy !== 1'b1 || bus.lock_lost !== 1'b1) begin errors++; $display("FAIL pre_reset busy=%b lost=%b exp=1/1", bus.div_busy, bus.lock_lost); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.rst_out !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL mid_reset_rst rst_out=%b ready=%b exp=1/0", bus.rst_out, bus.ready); end
    checks++; if (bus.div_busy !== 1'b0 || bus.lock_lost !== 1'b0 || bus.ce_out !== 3'b000) begin errors++; $display("FAIL mid_reset_state busy=%b lost=%b ce=%b exp=0/0/000", bus.div_busy, bus.lock_lost, bus.ce_out); end
`ifdef CLK_RST_LOCK_LOSS_CNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_cnt got=%0d exp=0", bus.lock_loss_cnt); end
`endif
    step();
    reset = 1'b0;
    repeat (REL) step();
    checks++; if (bus.rst_out !== 1'b0) begin errors++; $display("FAIL post_reset_release got=%b exp=0", bus.rst_out); end
    for (int c = 0; c < 2; c++) begin
      if (c > 0) step();
      checks++; if (bus.ce_out !== 3'b111 || bus.div_busy !== 1'b0) begin errors++; $display("FAIL default_div cycle=%0d ce=%b busy=%b exp=111/0", c, bus.ce_out, bus.div_busy); end
    end
  endtask

`ifdef CLK_RST_LOCK_LOSS_CNT_EN
  task automatic test_loss_sat();
    for (int n = 0; n < 300; n++) begin
      bus.pll_locked = 1'b0;
      repeat (LOSS) step();
      bus.pll_locked = 1'b1;
      repeat (REL) step();
    end
    checks++; if (bus.lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL loss_cnt_sat got=%0d exp=255", bus.lock_loss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_write();
    test_glitch();
    test_release();
    test_ce();
    test_run_write();
    test_loss();
    test_reset_mid();
`ifdef CLK_RST_LOCK_LOSS_CNT_EN
    test_loss_sat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
